// File: rtl/freq_serial_channel.sv
// freq_serial_channel: one channel of a pattern serializer with a
// per-bit selectable bit period (fast / slow), one-shot or repeat mode.
module freq_serial_channel #(
    parameter int          DATA_BIT   = 32,
    parameter int          CH_ID      = 0,
    parameter logic [7:0]  CMD_PERIOD = 8'h01,
    parameter logic [7:0]  CMD_FREQ   = 8'h02,
    parameter logic [7:0]  CMD_DATA   = 8'h03,
    parameter logic [7:0]  CMD_CTRL   = 8'h04
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [7:0]          cmd_i,
    input  logic                done_tick_i,
    input  logic [DATA_BIT-1:0] output_pattern_i,
    input  logic [DATA_BIT-1:0] freq_pattern_i,
    input  logic [3:0]          sel_out_i,
    input  logic                mode_i,
    input  logic                enable_i,
    input  logic                stop_i,
    input  logic [7:0]          slow_period_i,
    input  logic [7:0]          fast_period_i,
    output logic                serial_o,
    output logic                busy_o,
    output logic                done_tick_o
);

    localparam int CW = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(DATA_BIT - 1);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic                mode_q;
    logic [7:0]          slow_q, fast_q;
    logic [DATA_BIT-1:0] freq_q, shadow_q;
    logic [DATA_BIT-1:0] shift_q, fsel_q;
    logic [CW-1:0]       bit_cnt_q;
    logic [7:0]          hold_q;
    logic                done_q;

    logic                sel_hit;
    logic                per_wr, frq_wr, dat_wr, ctl_wr;
    logic                ctl_stop, ctl_start;
    logic                bit_end, pass_end;
    logic                load, advance;
    logic [CW-1:0]       bit_nxt;
    logic [7:0]          p_load, p_adv;
    logic [7:0]          hold_load, hold_adv;

    // Decode the command strobe into register writes and control requests
    always_comb begin
        sel_hit   = (sel_out_i == 4'(CH_ID));
        per_wr    = done_tick_i && (cmd_i == CMD_PERIOD);
        frq_wr    = done_tick_i && (cmd_i == CMD_FREQ);
        dat_wr    = done_tick_i && (cmd_i == CMD_DATA) && sel_hit;
        ctl_wr    = done_tick_i && (cmd_i == CMD_CTRL) && sel_hit;
        ctl_stop  = ctl_wr && stop_i;
        ctl_start = ctl_wr && !stop_i && enable_i;
    end

    // Bit/pass boundary detection and hold-count reload values
    always_comb begin
        bit_end   = (state_q == RUN) && (hold_q == 8'd0);
        pass_end  = bit_end && (bit_cnt_q == LAST);
        load      = ctl_start || (pass_end && mode_q && !ctl_stop);
        advance   = bit_end && !pass_end && !ctl_wr;
        bit_nxt   = bit_cnt_q + CW'(1);
        p_load    = freq_q[0] ? fast_q : slow_q;
        p_adv     = fsel_q[bit_nxt] ? fast_q : slow_q;
        hold_load = (p_load == 8'd0) ? 8'd0 : p_load - 8'd1;
        hold_adv  = (p_adv == 8'd0) ? 8'd0 : p_adv - 8'd1;
    end

    // State register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next state: stop beats start, start beats the pass-end decision
    always_comb begin
        state_d = state_q;
        if (ctl_stop)                 state_d = IDLE;
        else if (ctl_start)           state_d = RUN;
        else if (pass_end && !mode_q) state_d = IDLE;
    end

    // Outputs: line is forced low whenever the channel is idle
    always_comb begin
        busy_o      = (state_q == RUN);
        serial_o    = (state_q == RUN) && shift_q[0];
        done_tick_o = done_q;
    end

    // Configuration, shadow registers and the serializing datapath
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q    <= 1'b0;
            slow_q    <= '0;
            fast_q    <= '0;
            freq_q    <= '0;
            shadow_q  <= '0;
            shift_q   <= '0;
            fsel_q    <= '0;
            bit_cnt_q <= '0;
            hold_q    <= '0;
            done_q    <= 1'b0;
        end else begin
            if (per_wr) begin
                slow_q <= slow_period_i;
                fast_q <= fast_period_i;
            end
            if (frq_wr) freq_q   <= freq_pattern_i;
            if (dat_wr) shadow_q <= output_pattern_i;
            if (ctl_wr) mode_q   <= mode_i;
            done_q <= pass_end;
            if (load) begin
                shift_q   <= shadow_q;
                fsel_q    <= freq_q;
                bit_cnt_q <= '0;
                hold_q    <= hold_load;
            end else if (advance) begin
                shift_q   <= shift_q >> 1;
                bit_cnt_q <= bit_nxt;
                hold_q    <= hold_adv;
            end else if (state_q == RUN && hold_q != 8'd0) begin
                hold_q    <= hold_q - 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_freq_serial_channel.sv
// Directed self-checking bench for freq_serial_channel (CH_ID = 5).
// Inputs change on the falling edge; outputs are sampled there too.
module tb_freq_serial_channel;

    localparam logic [7:0] C_PER  = 8'h01;
    localparam logic [7:0] C_FRQ  = 8'h02;
    localparam logic [7:0] C_DAT  = 8'h03;
    localparam logic [7:0] C_CTL  = 8'h04;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [7:0]  cmd_i = 8'h00;
    logic        done_tick_i = 1'b0;
    logic [31:0] output_pattern_i = '0;
    logic [31:0] freq_pattern_i = '0;
    logic [3:0]  sel_out_i = 4'd0;
    logic        mode_i = 1'b0;
    logic        enable_i = 1'b0;
    logic        stop_i = 1'b0;
    logic [7:0]  slow_period_i = 8'd0;
    logic [7:0]  fast_period_i = 8'd0;
    logic        serial_o;
    logic        busy_o;
    logic        done_tick_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk_i = ~clk_i;

    freq_serial_channel #(
        .DATA_BIT(32),
        .CH_ID(5),
        .CMD_PERIOD(C_PER),
        .CMD_FREQ(C_FRQ),
        .CMD_DATA(C_DAT),
        .CMD_CTRL(C_CTL)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .cmd_i(cmd_i),
        .done_tick_i(done_tick_i),
        .output_pattern_i(output_pattern_i),
        .freq_pattern_i(freq_pattern_i),
        .sel_out_i(sel_out_i),
        .mode_i(mode_i),
        .enable_i(enable_i),
        .stop_i(stop_i),
        .slow_period_i(slow_period_i),
        .fast_period_i(fast_period_i),
        .serial_o(serial_o),
        .busy_o(busy_o),
        .done_tick_o(done_tick_o)
    );

    // Expected line level at clock 'pos' of a pass
    function automatic logic exp_bit(input logic [31:0] d, input logic [31:0] f,
                                     input logic [7:0] s, input logic [7:0] fa,
                                     input int pos);
        int t;
        int p;
        t = pos;
        for (int i = 0; i < 32; i++) begin
            p = f[i] ? int'(fa) : int'(s);
            if (p == 0) p = 1;
            if (t < p) return d[i];
            t = t - p;
        end
        return 1'b0;
    endfunction

    task automatic send(input logic [7:0] c, input logic [3:0] s,
                        input logic [31:0] d, input logic [31:0] f,
                        input logic m, input logic en, input logic st,
                        input logic [7:0] sp, input logic [7:0] fp);
        cmd_i = c; sel_out_i = s; output_pattern_i = d;
        freq_pattern_i = f; mode_i = m; enable_i = en; stop_i = st;
        slow_period_i = sp; fast_period_i = fp;
        done_tick_i = 1'b1;
        @(negedge clk_i);
        done_tick_i = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_i);
        n_checks++;
        if ({serial_o, busy_o, done_tick_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b want=000", {serial_o, busy_o, done_tick_o});
        end
        rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        n_checks++;
        if ({serial_o, busy_o, done_tick_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL post_reset_idle got=%b want=000", {serial_o, busy_o, done_tick_o});
        end
    endtask

    task automatic test_config();
        send(C_PER, 4'd9, '0, '0, 0, 0, 0, 8'h14, 8'h05);
        send(C_FRQ, 4'd1, '0, 32'h11223344, 0, 0, 0, 8'h14, 8'h05);
        send(C_DAT, 4'd5, 32'hBBCCDDEE, '0, 0, 0, 0, 8'h14, 8'h05);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL config_no_start busy=%b want=0", busy_o);
        end
    endtask

    task automatic test_wrong_channel();
        send(C_DAT, 4'd3, 32'h12345678, '0, 0, 0, 0, 8'h14, 8'h05);
        send(C_CTL, 4'd3, '0, '0, 1, 1, 0, 8'h14, 8'h05);
        repeat (4) @(negedge clk_i);
        n_checks++;
        if ({busy_o, serial_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL other_channel_ctrl got=%b want=00", {busy_o, serial_o});
        end
        send(8'h77, 4'd5, '0, '0, 1, 1, 0, 8'h14, 8'h05);
        repeat (2) @(negedge clk_i);
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL unknown_cmd busy=%b want=0", busy_o);
        end
        cmd_i = C_CTL; sel_out_i = 4'd5; enable_i = 1'b1; mode_i = 1'b1;
        repeat (3) @(negedge clk_i);
        enable_i = 1'b0;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL no_strobe busy=%b want=0", busy_o);
        end
    endtask

    // One-shot: also shows the ch3 DATA write left the shadow untouched
    task automatic test_oneshot();
        logic [2:0] exp;
        int dones;
        dones = 0;
        send(C_CTL, 4'd5, '0, '0, 0, 1, 0, 8'h14, 8'h05);
        for (int n = 0; n < 500; n++) begin
            if (n < 490)
                exp = {1'b1, 1'b0, exp_bit(32'hBBCCDDEE, 32'h11223344, 8'h14, 8'h05, n)};
            else if (n == 490)
                exp = 3'b010;
            else
                exp = 3'b000;
            if (done_tick_o === 1'b1) dones++;
            n_checks++;
            if ({busy_o, done_tick_o, serial_o} !== exp) begin
                n_fail++;
                $display("FAIL oneshot_stream n=%0d got=%b want=%b", n,
                         {busy_o, done_tick_o, serial_o}, exp);
            end
            @(negedge clk_i);
        end
        n_checks++;
        if (dones !== 1) begin
            n_fail++;
            $display("FAIL oneshot_done_count got=%0d want=1", dones);
        end
    endtask

    // Repeat mode with a DATA update arriving mid-pass
    task automatic test_repeat();
        logic [2:0]  exp;
        logic [31:0] d;
        int pos;
        send(C_CTL, 4'd5, '0, '0, 1, 1, 0, 8'h14, 8'h05);
        for (int n = 0; n < 1000; n++) begin
            done_tick_i = 1'b0;
            pos = n % 490;
            d = (n < 490) ? 32'hBBCCDDEE : 32'h0000FFFF;
            exp = {1'b1, (n > 0 && pos == 0),
                   exp_bit(d, 32'h11223344, 8'h14, 8'h05, pos)};
            n_checks++;
            if ({busy_o, done_tick_o, serial_o} !== exp) begin
                n_fail++;
                $display("FAIL repeat_stream n=%0d got=%b want=%b", n,
                         {busy_o, done_tick_o, serial_o}, exp);
            end
            if (n == 100) begin
                cmd_i = C_DAT; sel_out_i = 4'd5;
                output_pattern_i = 32'h0000FFFF;
                done_tick_i = 1'b1;
            end
            @(negedge clk_i);
        end
        done_tick_i = 1'b0;
    endtask

    task automatic test_stop();
        int bad;
        bad = 0;
        send(C_CTL, 4'd5, '0, '0, 1, 0, 1, 8'h14, 8'h05);
        n_checks++;
        if ({busy_o, done_tick_o, serial_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL stop_next_edge got=%b want=000", {busy_o, done_tick_o, serial_o});
        end
        for (int n = 0; n < 600; n++) begin
            if (busy_o !== 1'b0 || done_tick_o !== 1'b0) bad++;
            @(negedge clk_i);
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++;
            $display("FAIL stop_stays_idle bad_cycles=%0d want=0", bad);
        end
    endtask

    // Zero periods mean one clock per bit; then reset lands mid-pass
    task automatic test_period_zero_and_reset();
        logic [2:0] exp;
        send(C_PER, 4'd0, '0, '0, 0, 0, 0, 8'h00, 8'h00);
        send(C_CTL, 4'd5, '0, '0, 1, 1, 0, 8'h00, 8'h00);
        for (int n = 0; n < 40; n++) begin
            exp = {1'b1, (n == 32),
                   exp_bit(32'h0000FFFF, 32'h11223344, 8'h00, 8'h00, n % 32)};
            n_checks++;
            if ({busy_o, done_tick_o, serial_o} !== exp) begin
                n_fail++;
                $display("FAIL p0_stream n=%0d got=%b want=%b", n,
                         {busy_o, done_tick_o, serial_o}, exp);
            end
            @(negedge clk_i);
        end
        rst_i = 1'b1;
        #1;
        n_checks++;
        if ({busy_o, done_tick_o, serial_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL async_reset got=%b want=000", {busy_o, done_tick_o, serial_o});
        end
        @(negedge clk_i);
        rst_i = 1'b0;
        repeat (10) @(negedge clk_i);
        n_checks++;
        if ({busy_o, done_tick_o, serial_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_after_reset got=%b want=000", {busy_o, done_tick_o, serial_o});
        end
    endtask

    initial begin
        @(negedge clk_i);
        test_reset();
        test_config();
        test_wrong_channel();
        test_oneshot();
        test_repeat();
        test_stop();
        test_period_zero_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
